// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish in one edge, MUL runs a shift-add
// over WIDTH cycles. One request in flight; result held until out_ready.
module alu_seq #(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       op_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             op_err,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic               accept, is_mul, mul_last;
   logic [2*WIDTH-1:0] mcand, prod, prod_fin;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v, alu_err;
   logic [WIDTH:0]     sum, diff, shl_ext;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && (state == IDLE);
   assign is_mul    = (MUL_EN != 0) && (op_select == 3'b101);
   assign mul_last  = (state == BUSY) && (cnt == CW'(WIDTH - 1));
   assign prod_fin  = prod + (mplier[0] ? mcand : '0);

   // Single-cycle datapath; bit WIDTH of each extended value is carry/borrow/last-out
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      sum     = {1'b0, op_a} + {1'b0, op_b};
      diff    = {1'b0, op_a} - {1'b0, op_b};
      shl_ext = {1'b0, op_a} << op_b;
      case (op_select)
         3'b000: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         3'b001: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         3'b010: alu_res = ~(op_a & op_b);
         3'b011: alu_res = op_a;
         3'b100: alu_res = op_b;
         3'b110: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = is_mul ? BUSY : DONE;
         BUSY:    if (mul_last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
         op_err <= 1'b0;
         mcand  <= '0;
         prod   <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (accept) begin
         if (is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            prod   <= '0;
            cnt    <= '0;
         end else begin
            result <= alu_res;
            flag_z <= (alu_res == '0) && !alu_err;
            flag_n <= alu_res[WIDTH-1];
            flag_c <= alu_c;
            flag_v <= alu_v;
            op_err <= alu_err;
         end
      end else if (state == BUSY) begin
         // One multiplier bit per cycle; the last step folds straight into the result
         prod   <= prod_fin;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (mul_last) begin
            result <= prod_fin[WIDTH-1:0];
            flag_z <= (prod_fin[WIDTH-1:0] == '0);
            flag_n <= prod_fin[WIDTH-1];
            flag_c <= |prod_fin[2*WIDTH-1:WIDTH];
            flag_v <= 1'b0;
            op_err <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width in bits (legal range 4..64).
REQ-002 SHALL have parameter MUL_EN, default 1: 1 enables the iterative multiply; 0 treats opcode 101 as reserved.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op_a  input  WIDTH  operand A.
REQ-008 SHALL have port op_b  input  WIDTH  operand B.
REQ-009 SHALL have port op_select  input  3  operation code.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have ports flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/borrow, signed overflow.
REQ-014 SHALL have port op_err  output  1  reserved opcode was issued.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 Opcodes SHALL be: 000 ADD, 001 SUB, 010 NAND, 011 PASS_A, 100 PASS_B, 101 MUL (low WIDTH bits of the product), 110 SHL (op_a shifted left by op_b, zero fill), 111 reserved.
REQ-017 The FSM SHALL have the states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 An acceptance occurs at an edge where in_valid=1 and in_ready=1; op_a, op_b and op_select SHALL be captured at that edge, and later input changes SHALL be ignored.
REQ-019 For every opcode except MUL, at the accepting edge the block SHALL register the result and flags and go IDLE->DONE, so out_valid=1 in the following cycle (latency 1).
REQ-020 For MUL, the accepting edge SHALL move the FSM IDLE->BUSY; a shift-add runs one bit per cycle over WIDTH cycles with an internal counter, and the FSM goes BUSY->DONE at accepting edge + WIDTH.
REQ-021 In DONE, out_valid=1 and result and all flags SHALL hold stable until an edge with out_ready=1, which SHALL move DONE->IDLE; there is no overlap between requests.
REQ-022 ADD: flag_c SHALL be the carry out; flag_v SHALL be the signed overflow.
REQ-023 SUB: result = op_a - op_b modulo 2^WIDTH; flag_c SHALL be 1 iff op_a < op_b unsigned (borrow); flag_v SHALL be the signed overflow.
REQ-024 MUL: flag_c SHALL be 1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero; flag_v SHALL be 0.
REQ-025 SHL: a shift amount >= WIDTH SHALL give result 0; flag_c SHALL be the last bit shifted out (0 for a shift of 0); flag_v SHALL be 0.
REQ-026 NAND, PASS_A, PASS_B: flag_c and flag_v SHALL be 0.
REQ-027 flag_z SHALL be (result == 0) and flag_n SHALL be result[WIDTH-1], for all valid opcodes.
REQ-028 Reserved opcode: result 0, all flags 0, op_err=1, latency 1; op_err SHALL be 0 for every valid opcode.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, out_valid=0, result=0, all flags 0, op_err=0 and busy=0, and clear the MUL counter and partial product; in_ready SHALL be 1 while in reset.
REQ-030 Reset asserted mid-MUL or in DONE SHALL discard the operation with no output.
REQ-031 The first acceptance after rst_n deasserts SHALL behave exactly as after power-up.

Verification
REQ-032 ADD 0xFFFF+0x0001 (WIDTH=16) -> result 0x0000, flag_z=1, flag_c=1, flag_v=0, out_valid=1 in the cycle after acceptance.
REQ-033 SUB 0x8000-0x0001 -> result 0x7FFF, flag_v=1, flag_c=0, flag_n=0; SUB 0x0001-0x0002 -> result 0xFFFF, flag_c=1, flag_n=1.
REQ-034 MUL 0x0123*0x0010 -> result 0x1230, flag_c=0, busy=1 for 16 cycles before out_valid; MUL 0x1000*0x0010 -> result 0x0000, flag_z=1, flag_c=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags unchanged, in_ready=0, a new in_valid pulse is ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 Assert rst_n=0 at cycle 8 of a MUL -> all outputs 0 with no clock edge needed; after release, PASS_A 0x00AA -> result 0x00AA.
REQ-037 op_select=111 -> result 0, op_err=1, flags 0; SHL 0x0001 by 16 -> result 0, flag_z=1.
